// File: rtl/fp_mult_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined fp_multiplier between NREQ requesters.
// Requester tags ride a delay line matched to the multiplier so each product returns to its issuer.
module fp_mult_sched #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned LATENCY = 14,
   parameter int unsigned IDW     = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NREQ-1:0]                 req_valid,
   input  logic [32*NREQ-1:0]              req_a,
   input  logic [32*NREQ-1:0]              req_b,
   output logic [NREQ-1:0]                 req_ready,
   output logic [31:0]                     mul_a,
   output logic [31:0]                     mul_b,
   input  logic [31:0]                     mul_out,
   output logic [NREQ-1:0]                 res_valid,
   output logic [31:0]                     res_data,
   input  logic                            drain,
   output logic                            idle,
   output logic [$clog2(LATENCY+2)-1:0]    inflight
);

   localparam int unsigned DW    = 32;
   localparam int unsigned CW    = $clog2(LATENCY + 2);
   localparam int unsigned DEPTH = LATENCY + 1;

   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   gnt_id;
   logic [IDW-1:0]   scan_idx;
   logic             hs;
   logic [DW-1:0]    sel_a;
   logic [DW-1:0]    sel_b;
   logic [DEPTH-1:0] tag_vld;
   logic [IDW-1:0]   tag_id [DEPTH];
   logic [CW-1:0]    inflight_nxt;

   // Round-robin grant: first valid requester at or after the pointer, none while draining
   always_comb begin
      req_ready = '0;
      gnt_id    = '0;
      hs        = 1'b0;
      scan_idx  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_idx = IDW'((32'(ptr) + k) % NREQ);
         if (!drain && !hs && req_valid[scan_idx]) begin
            req_ready[scan_idx] = 1'b1;
            gnt_id              = scan_idx;
            hs                  = 1'b1;
         end
      end
   end

   // Operand mux driven by the one-hot grant
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            sel_a = req_a[i*DW +: DW];
            sel_b = req_b[i*DW +: DW];
         end
      end
   end

   always_comb begin
      inflight_nxt = inflight;
      if (hs && !tag_vld[DEPTH-1]) begin
         inflight_nxt = inflight + CW'(1);
      end else if (!hs && tag_vld[DEPTH-1]) begin
         inflight_nxt = inflight - CW'(1);
      end
   end

   // Issue side: pointer and multiplier operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= '0;
         mul_a <= '0;
         mul_b <= '0;
      end else if (hs) begin
         ptr   <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
         mul_a <= sel_a;
         mul_b <= sel_b;
      end
   end

   // Tag delay line: stage LATENCY lines up with the product on mul_out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tag_id[i] <= '0;
         end
      end else begin
         tag_vld   <= {tag_vld[DEPTH-2:0], hs};
         tag_id[0] <= gnt_id;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            tag_id[i] <= tag_id[i-1];
         end
      end
   end

   // Return side: result strobe, data capture and occupancy tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= '0;
         res_data  <= '0;
         inflight  <= '0;
         idle      <= 1'b1;
      end else begin
         res_valid <= tag_vld[DEPTH-1] ? (NREQ'(1) << tag_id[DEPTH-1]) : '0;
         if (tag_vld[DEPTH-1]) begin
            res_data <= mul_out;
         end
         inflight <= inflight_nxt;
         idle     <= (inflight_nxt == '0);
      end
   end

endmodule

// File: tb/tb_fp_mult_sched.sv
// Bench for fp_mult_sched: behavioural multiplier, round-robin reference and result scoreboard.
module tb_fp_mult_sched;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned LATENCY = 14;
   localparam int unsigned IDW     = 2;
   localparam int unsigned CW      = $clog2(LATENCY + 2);

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [32*NREQ-1:0]   req_a = '0;
   logic [32*NREQ-1:0]   req_b = '0;
   logic [NREQ-1:0]      req_ready;
   logic [31:0]          mul_a, mul_b, mul_out;
   logic [NREQ-1:0]      res_valid;
   logic [31:0]          res_data;
   logic                 drain = 1'b0;
   logic                 idle;
   logic [CW-1:0]        inflight;

   fp_mult_sched #(.NREQ(NREQ), .LATENCY(LATENCY), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
      .res_valid(res_valid), .res_data(res_data), .drain(drain), .idle(idle),
      .inflight(inflight)
   );

   always #5 clk = ~clk;

   // Single-precision multiply, round-to-nearest-even, subnormals flushed to zero
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic s, g, st;
      int ea, eb, e;
      logic [47:0] p;
      logic [23:0] m;
      logic [24:0] mr;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
      if (ea == 255 || eb == 255) begin
         if (ea == 0 || eb == 0) return 32'h7FC00000;
         return {s, 8'hFF, 23'h0};
      end
      if (ea == 0 || eb == 0) return {s, 31'h0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = ea + eb - 127;
      if (p[47]) begin
         m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 1;
      end else begin
         m = p[46:23]; g = p[22]; st = |p[21:0];
      end
      mr = {1'b0, m} + 25'(g && (st || m[0]));
      if (mr[24]) begin
         mr = mr >> 1; e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0) return {s, 31'h0};
      return {s, 8'(e), mr[22:0]};
   endfunction

   // Pipelined multiplier: operands captured on an edge appear on mul_out LATENCY edges later
   logic [31:0] mpipe [LATENCY];
   always @(posedge clk) begin
      mpipe[0] <= fmul(mul_a, mul_b);
      for (int i = 1; i < int'(LATENCY); i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_out = mpipe[LATENCY-1];

   typedef struct {
      int unsigned id;
      logic [31:0] data;
      int          due;
      int          hs_edge;
   } exp_t;

   exp_t        sbq[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int unsigned mptr = 0;
   logic [31:0] exp_mul_a = '0;
   logic [31:0] exp_mul_b = '0;
   logic [31:0] stim_a [NREQ];
   logic [31:0] stim_b [NREQ];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard when a result is due and checks occupancy every cycle
   always @(negedge clk) begin
      int n;
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
         chk("res_missed", 64'(sbq[0].due), 64'(cyc));
         void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         chk("res_valid", 64'(res_valid), 64'(NREQ'(1) << sbq[0].id));
         chk("res_data", 64'(res_data), 64'(sbq[0].data));
         void'(sbq.pop_front());
      end else begin
         chk("res_valid_quiet", 64'(res_valid), 64'(0));
      end
      n = 0;
      foreach (sbq[i]) if (sbq[i].hs_edge <= cyc) n++;
      chk("inflight", 64'(inflight), 64'(n));
      chk("idle", 64'(idle), 64'(n == 0));
   end

   // One cycle of stimulus; the reference grant is computed from the rotating priority rule
   task automatic step(input logic [NREQ-1:0] v, input logic dr);
      int g;
      @(negedge clk);
      chk("mul_a", 64'(mul_a), 64'(exp_mul_a));
      chk("mul_b", 64'(mul_b), 64'(exp_mul_b));
      req_valid = v;
      drain     = dr;
      for (int i = 0; i < int'(NREQ); i++) begin
         req_a[i*32 +: 32] = stim_a[i];
         req_b[i*32 +: 32] = stim_b[i];
      end
      #1;
      g = -1;
      if (!dr) begin
         for (int k = 0; k < int'(NREQ); k++) begin
            int i;
            i = (int'(mptr) + k) % int'(NREQ);
            if (g < 0 && v[i]) g = i;
         end
      end
      chk("req_ready", 64'(req_ready), (g < 0) ? 64'(0) : 64'(NREQ'(1) << g));
      if (g >= 0) begin
         sbq.push_back('{id: g, data: fmul(stim_a[g], stim_b[g]),
                         due: cyc + 1 + int'(LATENCY) + 1, hs_edge: cyc + 1});
         exp_mul_a = stim_a[g];
         exp_mul_b = stim_b[g];
         mptr = (g + 1) % NREQ;
      end
   endtask

   task automatic set_all(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < int'(NREQ); i++) begin
         stim_a[i] = a;
         stim_b[i] = b;
      end
   endtask

   task automatic randomize_data();
      logic [31:0] sp [4];
      sp[0] = 32'h00000000; sp[1] = 32'h7F800000; sp[2] = 32'h7FC00000; sp[3] = 32'h3F800000;
      for (int i = 0; i < int'(NREQ); i++) begin
         stim_a[i] = ($urandom_range(0, 7) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
         stim_b[i] = ($urandom_range(0, 7) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
      end
   endtask

   task automatic wait_idle(input logic dr);
      int n;
      n = 0;
      while (!(idle && sbq.size() == 0) && n < 40) begin
         step('0, dr);
         n++;
      end
      chk("wait_idle", 64'(idle && sbq.size() == 0), 64'(1));
   endtask

   initial begin
      set_all(32'h0, 32'h0);
      #12;
      chk("reset_res_valid", 64'(res_valid), 64'(0));
      chk("reset_res_data", 64'(res_data), 64'(0));
      chk("reset_mul_a", 64'(mul_a), 64'(0));
      chk("reset_inflight", 64'(inflight), 64'(0));
      chk("reset_idle", 64'(idle), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;

      // Single op from requester 1: 2.0 x 3.0
      set_all(32'h0, 32'h0);
      stim_a[1] = 32'h40000000;
      stim_b[1] = 32'h40400000;
      step(4'b0010, 1'b0);
      step('0, 1'b0);
      wait_idle(1'b0);

      // All requesters continuously valid: 1.5 x 1.5
      set_all(32'h3FC00000, 32'h3FC00000);
      for (int i = 0; i < 40; i++) step('1, 1'b0);
      wait_idle(1'b0);

      // Pointer moved to 1, then requesters 0 and 2 contend; then a lone requester 3
      randomize_data();
      step(4'b0001, 1'b0);
      for (int i = 0; i < 3; i++) begin randomize_data(); step(4'b0101, 1'b0); end
      for (int i = 0; i < 4; i++) begin randomize_data(); step(4'b1000, 1'b0); end
      wait_idle(1'b0);

      // Drain with five operations in flight
      for (int i = 0; i < 5; i++) begin randomize_data(); step('1, 1'b0); end
      for (int i = 0; i < 4; i++) begin randomize_data(); step('1, 1'b1); end
      wait_idle(1'b1);
      step('0, 1'b0);

      // Asynchronous reset between edges with seven operations in flight
      for (int i = 0; i < 7; i++) begin randomize_data(); step('1, 1'b0); end
      @(posedge clk);
      #3;
      req_valid = '0;
      rst_n     = 1'b0;
      #1;
      sbq.delete();
      mptr = 0;
      exp_mul_a = '0;
      exp_mul_b = '0;
      chk("async_res_valid", 64'(res_valid), 64'(0));
      chk("async_res_data", 64'(res_data), 64'(0));
      chk("async_mul_a", 64'(mul_a), 64'(0));
      chk("async_inflight", 64'(inflight), 64'(0));
      chk("async_idle", 64'(idle), 64'(1));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      randomize_data();
      step(4'b0001, 1'b0);
      wait_idle(1'b0);

      // Special values from ids 0 then 3, back to back
      set_all(32'h0, 32'h0);
      stim_a[0] = 32'h00000000; stim_b[0] = 32'h7F800000;
      stim_a[3] = 32'h7F800000; stim_b[3] = 32'h3F800000;
      step(4'b0001, 1'b0);
      step(4'b1000, 1'b0);
      wait_idle(1'b0);

      // Randomized traffic with occasional drain
      for (int i = 0; i < 400; i++) begin
         logic [NREQ-1:0] v;
         randomize_data();
         v = NREQ'($urandom);
         step(v, $urandom_range(0, 9) == 0);
      end
      wait_idle(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_mult_sched.md
Name: fp_mult_sched

Overview:
- Round-robin scheduler that shares one pipelined fp_multiplier (fixed latency, no stall input) between NREQ requesters.
- Accepts operand pairs over valid/ready, registers them onto the multiplier inputs, and carries a requester tag through a delay line matched to the multiplier latency.
- Returns each product to the requester that issued it, with a one-hot result strobe.
- Provides drain/idle control for the flush and reconfiguration sequencing used by the FP unit top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LATENCY, 14, fp_multiplier cycles from operand capture to valid product.
- IDW, 2, requester id width; must be at least clog2(NREQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operand-valid.
- req_a  input  32*NREQ  operand A per requester, IEEE-754 single; slice i = [32i+31:32i].
- req_b  input  32*NREQ  operand B per requester, same packing.
- req_ready  output  NREQ  one-hot grant; handshake when req_valid[i] & req_ready[i].
- mul_a  output  32  registered operand A to fp_multiplier.
- mul_b  output  32  registered operand B to fp_multiplier.
- mul_out  input  32  fp_multiplier product.
- res_valid  output  NREQ  registered one-hot result strobe, single cycle.
- res_data  output  32  registered product, valid only while res_valid is nonzero.
- drain  input  1  level; while high, no new grants.
- idle  output  1  high when nothing is in flight and no result is pending.
- inflight  output  clog2(LATENCY+2)  number of accepted operations whose result strobe has not yet fired.

Behaviour:
- Reset (async assert, sync-released use):
  - mul_a = 0, mul_b = 0, res_valid = 0, res_data = 0.
  - Tag delay line cleared to all invalid; inflight = 0; idle = 1.
  - Round-robin pointer = 0.
  - Reset mid-operation discards every in-flight result; no res_valid fires for operations accepted before reset.
- Arbitration:
  - req_ready is combinational from req_valid, drain and the pointer.
  - At most one bit of req_ready is set per cycle, and only for a requester with req_valid high.
  - Priority starts at the pointer index and wraps NREQ-1 -> 0.
  - After a handshake by requester g, the pointer becomes (g+1) mod NREQ. With no handshake, the pointer holds.
  - When drain = 1, req_ready = 0.
  - req_ready never depends on result-side state: the multiplier cannot stall and results cannot be back-pressured.
- Issue:
  - On the handshake edge, mul_a/mul_b load the granted slices, and tag {valid=1, id=g} enters stage 0 of the delay line.
  - With no handshake, mul_a/mul_b hold their value and an invalid tag enters.
  - Throughput is one operation per cycle.
- Return:
  - The delay line is sized so that res_valid[id] = 1 and res_data = mul_out are registered on edge E+LATENCY+1, where E is the handshake edge.
  - Example: LATENCY = 14, handshake at edge 0, result strobe visible after edge 15.
  - Results come back strictly in issue order. A back-to-back issue stream produces a back-to-back result stream.
  - When no valid tag arrives, res_valid = 0 and res_data holds its previous value.
- inflight counter:
  - +1 on a handshake; -1 on an edge that registers res_valid.
  - Both on the same edge: no change.
  - Never exceeds LATENCY+1; never wraps.
- idle = (inflight == 0). The drain sequence is: assert drain, wait for idle = 1, then reconfigure.
- Requester contract: req_a/req_b need only be stable in the handshake cycle. A requester may drop req_valid without a handshake; nothing is issued.
- Special-value handling (zero, inf, NaN) belongs entirely to the multiplier; the scheduler passes data through untouched.

Test Plan:
- Single op, reset release, then requester 1 presents a = 0x40000000, b = 0x40400000 for one cycle -> req_ready = 0010 that cycle; res_valid = 0010 and res_data = 0x40C00000 exactly 15 edges later; inflight goes 1 -> 0; idle returns to 1.
- All four requesters hold req_valid continuously, each with a = b = 0x3FC00000 -> grants rotate 0,1,2,3,0,...; results arrive on consecutive cycles in the same id order, each = 0x40100000; inflight saturates at 15, never 16.
- Requesters 0 and 2 valid with the pointer at 1 -> grant 2 first, then 0, then 2; a lone requester 3 is granted every cycle.
- drain asserted mid-stream with 5 ops in flight -> req_ready = 0 from that cycle; 5 result strobes follow; idle = 1 on the edge after the last strobe.
- rst_n pulsed low asynchronously (between edges) with 7 ops in flight -> outputs clear immediately; no res_valid for the lost ops; a new op after release returns correctly with a 15-edge latency.
- Special values: 0x00000000 x 0x7F800000 and 0x7F800000 x 0x3F800000 back-to-back from ids 0 and 3 -> res_data equals the multiplier's NaN then inf encodings, routed to res_valid 0001 then 1000.
